// File: rtl/rx_fifo_ctrl_if.sv
// rtl/rx_fifo_ctrl_if.sv - request and status-write signal bundle of the CAN receive FIFO controller
interface rx_fifo_ctrl_if #(
  parameter int PTR_W = 2
);
  logic             st_req;
  logic             rel_req;
  logic             clr_ovr;
  logic [PTR_W-1:0] b_ptr;
  logic             wrn;
  logic [1:0]       dsc_in;
  logic [PTR_W-1:0] a_ptr;
  logic [PTR_W:0]   msg_cnt;
  logic             rbs;
  logic             fifo_full;
  logic             data_ovr;
  logic             ovr_irq;

  modport master (
    output st_req, rel_req, clr_ovr,
    input  b_ptr, wrn, dsc_in, a_ptr, msg_cnt, rbs, fifo_full, data_ovr, ovr_irq
  );

  modport slave (
    input  st_req, rel_req, clr_ovr,
    output b_ptr, wrn, dsc_in, a_ptr, msg_cnt, rbs, fifo_full, data_ovr, ovr_irq
  );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// rtl/rx_fifo_ctrl.sv - 4-slot CAN receive FIFO pointer/status-write controller
// Optional overrun interrupt pulse: define RX_FIFO_OVR_IRQ_EN.
module rx_fifo_ctrl #(
  parameter int PTR_W = 2,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rsn,
  rx_fifo_ctrl_if.slave  fif
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ST_WR, CLR_WR} state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, st_slot, clr_slot, b_ptr;
  logic [PTR_W:0]   msg_cnt;
  logic [1:0]       dsc_in;
  logic             st_pend, clr_pend, ovr_pend, data_ovr, wrn;
  logic             full, empty, st_acc, rel_acc, st_rej;

  // A coincident release frees a slot, so a store into a full FIFO still succeeds.
  always_comb begin
    full    = (msg_cnt == FULL_CNT);
    empty   = (msg_cnt == '0);
    rel_acc = fif.rel_req && !empty;
    st_acc  = fif.st_req && (!full || rel_acc);
    st_rej  = fif.st_req && !st_acc;
  end

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (st_pend) state_n = ST_WR;
               else if (clr_pend) state_n = CLR_WR;
      ST_WR:   state_n = clr_pend ? CLR_WR : IDLE;
      CLR_WR:  state_n = st_pend ? ST_WR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Write-port outputs are loaded on the edge that enters the write state.
  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      wrn    <= 1'b1;
      b_ptr  <= '0;
      dsc_in <= 2'b00;
    end else begin
      wrn <= !(state_n == ST_WR || state_n == CLR_WR);
      if (state_n == ST_WR) begin
        b_ptr  <= st_slot;
        dsc_in <= {ovr_pend, 1'b1};
      end else if (state_n == CLR_WR) begin
        b_ptr  <= clr_slot;
        dsc_in <= 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_slot  <= '0;
      clr_slot <= '0;
      msg_cnt  <= '0;
      st_pend  <= 1'b0;
      clr_pend <= 1'b0;
      ovr_pend <= 1'b0;
      data_ovr <= 1'b0;
    end else begin
      if (st_acc) begin
        st_slot <= wr_ptr;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (rel_acc) begin
        clr_slot <= rd_ptr;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (st_acc && !rel_acc)      msg_cnt <= msg_cnt + 1'b1;
      else if (rel_acc && !st_acc) msg_cnt <= msg_cnt - 1'b1;
      // A new request or overrun wins over the write that consumes the old one.
      st_pend  <= st_acc || (st_pend && state_n != ST_WR);
      clr_pend <= rel_acc || (clr_pend && state_n != CLR_WR);
      ovr_pend <= st_rej || (ovr_pend && state_n != ST_WR);
      data_ovr <= st_rej || (data_ovr && !fif.clr_ovr);
    end
  end

`ifdef RX_FIFO_OVR_IRQ_EN
  logic ovr_irq;

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) ovr_irq <= 1'b0;
    else      ovr_irq <= st_rej;
  end

  assign fif.ovr_irq = ovr_irq;
`else
  assign fif.ovr_irq = 1'b0;
`endif

  assign fif.wrn       = wrn;
  assign fif.b_ptr     = b_ptr;
  assign fif.dsc_in    = dsc_in;
  assign fif.a_ptr     = rd_ptr;
  assign fif.msg_cnt   = msg_cnt;
  assign fif.rbs       = !empty;
  assign fif.fifo_full = full;
  assign fif.data_ovr  = data_ovr;
endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// tb/tb_rx_fifo_ctrl.sv - self-checking bench for rx_fifo_ctrl
module tb_rx_fifo_ctrl;
`ifdef RX_FIFO_OVR_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  always #5 clk = ~clk;

  rx_fifo_ctrl_if fif ();
  rx_fifo_ctrl dut (.clk(clk), .rsn(rsn), .fif(fif));

  int checks = 0;
  int errors = 0;

  // reference model: message count, slot indices and outstanding status writes
  int m_cnt, m_wr, m_rd, m_st_slot, m_clr_slot;
  bit m_st_pend, m_clr_pend, m_ovr, m_dovr, m_irq;
  bit exp_wrn;
  int exp_b, exp_dsc;
  int cyc_no = 0, last_st = -100, last_rel = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wr = 0; m_rd = 0; m_st_slot = 0; m_clr_slot = 0;
    m_st_pend = 0; m_clr_pend = 0; m_ovr = 0; m_dovr = 0; m_irq = 0;
    exp_wrn = 1; exp_b = 0; exp_dsc = 0;
  endtask

  task automatic check_all();
    chk("msg_cnt", 32'(fif.msg_cnt), m_cnt);
    chk("rbs", 32'(fif.rbs), 32'(m_cnt != 0));
    chk("fifo_full", 32'(fif.fifo_full), 32'(m_cnt == DEPTH));
    chk("a_ptr", 32'(fif.a_ptr), m_rd);
    chk("data_ovr", 32'(fif.data_ovr), 32'(m_dovr));
    chk("ovr_irq", 32'(fif.ovr_irq), 32'(m_irq));
    chk("wrn", 32'(fif.wrn), 32'(exp_wrn));
    if (!exp_wrn) begin
      chk("b_ptr", 32'(fif.b_ptr), exp_b);
      chk("dsc_in", 32'(fif.dsc_in), exp_dsc);
    end
  endtask

  // One clock: drive requests, advance the model by one edge, check at the next negedge.
  task automatic cyc(input bit st, input bit rel, input bit clr);
    bit rel_ok, st_ok, rej;
    fif.st_req = st; fif.rel_req = rel; fif.clr_ovr = clr;
    if (st) last_st = cyc_no;
    if (rel) last_rel = cyc_no;
    exp_wrn = 1;
    if (m_st_pend) begin
      exp_wrn = 0; exp_b = m_st_slot; exp_dsc = m_ovr ? 3 : 1;
      m_st_pend = 0; m_ovr = 0;
    end else if (m_clr_pend) begin
      exp_wrn = 0; exp_b = m_clr_slot; exp_dsc = 0;
      m_clr_pend = 0;
    end
    rel_ok = rel && (m_cnt > 0);
    st_ok  = st && (m_cnt < DEPTH || rel_ok);
    rej    = st && !st_ok;
    m_irq  = IRQ_EN && rej;
    if (rej) begin m_dovr = 1; m_ovr = 1; end
    else if (clr) m_dovr = 0;
    if (st_ok) begin
      m_st_pend = 1; m_st_slot = m_wr; m_wr = (m_wr + 1) % DEPTH; m_cnt++;
    end
    if (rel_ok) begin
      m_clr_pend = 1; m_clr_slot = m_rd; m_rd = (m_rd + 1) % DEPTH; m_cnt--;
    end
    @(negedge clk);
    cyc_no++;
    check_all();
    fif.st_req = 0; fif.rel_req = 0; fif.clr_ovr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rsn = 0;
    model_reset();
    #1;
    chk("rst_wrn", 32'(fif.wrn), 1);
    chk("rst_msg_cnt", 32'(fif.msg_cnt), 0);
    @(negedge clk);
    rsn = 1;
  endtask

  initial begin
    fif.st_req = 0; fif.rel_req = 0; fif.clr_ovr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_b_ptr", 32'(fif.b_ptr), 0);
    chk("rst_dsc_in", 32'(fif.dsc_in), 0);
    chk("rst_a_ptr", 32'(fif.a_ptr), 0);
    chk("rst_rbs", 32'(fif.rbs), 0);
    chk("rst_full", 32'(fif.fifo_full), 0);
    chk("rst_data_ovr", 32'(fif.data_ovr), 0);
    chk("rst_ovr_irq", 32'(fif.ovr_irq), 0);
    rsn = 1;

    // four stores fill the FIFO
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("fill_wrn", 32'(fif.wrn), 0);
      chk("fill_b_ptr", 32'(fif.b_ptr), k);
      chk("fill_dsc", 32'(fif.dsc_in), 1);
      idle(2);
    end
    chk("fill_cnt", 32'(fif.msg_cnt), 4);
    chk("fill_full", 32'(fif.fifo_full), 1);

    // overrun, then store after release carries the overrun marker
    cyc(1, 0, 0);
    chk("ovr_flag", 32'(fif.data_ovr), 1);
    chk("ovr_irq_pulse", 32'(fif.ovr_irq), 32'(IRQ_EN));
    cyc(0, 0, 0);
    chk("ovr_no_wr", 32'(fif.wrn), 1);
    chk("ovr_irq_end", 32'(fif.ovr_irq), 0);
    idle(2);
    cyc(0, 1, 0);
    idle(3);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("ovr_st_b_ptr", 32'(fif.b_ptr), 0);
    chk("ovr_st_dsc", 32'(fif.dsc_in), 3);
    idle(2);
    cyc(0, 1, 0);
    idle(3);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("next_st_dsc", 32'(fif.dsc_in), 1);
    idle(2);

    // simultaneous store and release with two messages held
    do_reset();
    cyc(1, 0, 0); idle(3);
    cyc(1, 0, 0); idle(3);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("sim_st_b_ptr", 32'(fif.b_ptr), 2);
    chk("sim_st_dsc", 32'(fif.dsc_in), 1);
    cyc(0, 0, 0);
    chk("sim_clr_wrn", 32'(fif.wrn), 0);
    chk("sim_clr_b_ptr", 32'(fif.b_ptr), 0);
    chk("sim_cnt", 32'(fif.msg_cnt), 2);
    chk("sim_a_ptr", 32'(fif.a_ptr), 1);
    idle(2);

    // release on empty, then a wrapping run
    do_reset();
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("empty_rel_wrn", 32'(fif.wrn), 1);
    chk("empty_rel_cnt", 32'(fif.msg_cnt), 0);
    for (int k = 0; k < 6; k++) begin
      idle(2);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("wrap_b_ptr", 32'(fif.b_ptr), k % 4);
      idle(2);
      cyc(0, 1, 0);
    end
    idle(3);

    // clr_ovr against a coincident overrun
    for (int k = 0; k < 4; k++) begin cyc(1, 0, 0); idle(3); end
    cyc(1, 0, 0); idle(3);
    cyc(1, 0, 1);
    chk("clr_vs_ovr", 32'(fif.data_ovr), 1);
    idle(3);
    cyc(0, 0, 1);
    chk("clr_alone", 32'(fif.data_ovr), 0);
    idle(2);

    // randomized traffic with varying fill bias
    for (int ph = 0; ph < 8; ph++) begin
      int p_st, p_rel;
      p_st  = (ph % 2 == 0) ? 80 : 25;
      p_rel = (ph % 2 == 0) ? 20 : 80;
      for (int i = 0; i < 100; i++) begin
        bit s, r, c;
        s = (cyc_no - last_st >= 3) && ($urandom_range(99) < p_st);
        r = (cyc_no - last_rel >= 3) && ($urandom_range(99) < p_rel);
        c = ($urandom_range(99) < 5);
        cyc(s, r, c);
      end
    end
    idle(3);

    // asynchronous reset in the middle of a store write
    do_reset();
    cyc(1, 0, 0);
    @(posedge clk);
    #1;
    chk("mid_wr_low", 32'(fif.wrn), 0);
    rsn = 0;
    #1;
    chk("mid_rst_wrn", 32'(fif.wrn), 1);
    chk("mid_rst_b_ptr", 32'(fif.b_ptr), 0);
    chk("mid_rst_dsc", 32'(fif.dsc_in), 0);
    chk("mid_rst_cnt", 32'(fif.msg_cnt), 0);
    chk("mid_rst_rbs", 32'(fif.rbs), 0);
    model_reset();
    @(negedge clk);
    rsn = 1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
